// File: rtl/apb_req_arbiter.sv
// apb_req_arbiter: round-robin arbiter and APB master for NREQ local requesters.
// One APB transfer at a time onto a MEM_SIZE-byte window at BASE_ADDR.
// Out-of-window commands never reach the bus and complete with an error.
// Optional feature: define APB_TIMEOUT_EN to abort ACCESS after TIMEOUT_CYCLES wait states.
module apb_req_arbiter #(
  parameter int unsigned            NREQ           = 4,
  parameter int unsigned            ADDR_WIDTH     = 32,
  parameter int unsigned            DATA_WIDTH     = 32,
  parameter int unsigned            DATA_STRB      = DATA_WIDTH / 8,
  parameter int unsigned            TIMEOUT_CYCLES = 16,
  parameter logic [ADDR_WIDTH-1:0]  BASE_ADDR      = 'hA200_0000,
  parameter int unsigned            MEM_SIZE       = 16
) (
  input  logic                         clk,
  input  logic                         nrst,
  input  logic [NREQ-1:0]              req,
  input  logic [NREQ*ADDR_WIDTH-1:0]   req_addr,
  input  logic [NREQ-1:0]              req_write,
  input  logic [NREQ*DATA_WIDTH-1:0]   req_wdata,
  input  logic [NREQ*DATA_STRB-1:0]    req_strb,
  input  logic [NREQ*3-1:0]            req_prot,
  output logic [NREQ-1:0]              gnt,
  output logic [NREQ-1:0]              done,
  output logic [DATA_WIDTH-1:0]        rsp_rdata,
  output logic                         rsp_err,
  output logic [ADDR_WIDTH-1:0]        paddr,
  output logic [2:0]                   pprot,
  output logic                         pwrite,
  output logic [DATA_WIDTH-1:0]        pwdata,
  output logic [DATA_STRB-1:0]         pstrb,
  output logic                         psel,
  output logic                         penable,
  input  logic                         pready,
  input  logic                         pslverr,
  input  logic [DATA_WIDTH-1:0]        prdata
);

  localparam int unsigned LGW = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam logic [ADDR_WIDTH:0] LIMIT = {1'b0, BASE_ADDR} + (ADDR_WIDTH+1)'(MEM_SIZE);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_SETUP  = 2'd1,
    S_ACCESS = 2'd2,
    S_REJECT = 2'd3
  } state_t;

  state_t r_state;
  state_t w_state_n;

  logic [LGW-1:0]        r_last_grant;
  logic [ADDR_WIDTH-1:0] r_addr;
  logic                  r_write;
  logic [DATA_WIDTH-1:0] r_wdata;
  logic [DATA_STRB-1:0]  r_strb;
  logic [2:0]            r_prot;
  logic [NREQ-1:0]       r_done;
  logic [DATA_WIDTH-1:0] r_rsp_rdata;
  logic                  r_rsp_err;

  logic [NREQ-1:0]       w_req_m;
  logic                  w_found;
  logic [LGW-1:0]        w_pick;
  logic [LGW:0]          w_sum;
  logic [ADDR_WIDTH-1:0] w_sel_addr;
  logic                  w_sel_write;
  logic [DATA_WIDTH-1:0] w_sel_wdata;
  logic [DATA_STRB-1:0]  w_sel_strb;
  logic [2:0]            w_sel_prot;
  logic                  w_in_range;
  logic [NREQ-1:0]       w_onehot;
  logic                  w_psel;
  logic                  w_penable;
  logic [NREQ-1:0]       w_gnt;
  logic                  w_tmo_hit;

  // Round-robin search starting one past the last grant; a requester is masked while its done pulses.
  always_comb begin
    w_req_m = req & ~r_done;
    w_found = 1'b0;
    w_pick  = '0;
    w_sum   = '0;
    for (int unsigned k = 1; k <= NREQ; k++) begin
      w_sum = {1'b0, r_last_grant} + (LGW+1)'(k);
      if (w_sum >= (LGW+1)'(NREQ)) begin
        w_sum = w_sum - (LGW+1)'(NREQ);
      end
      if (!w_found && w_req_m[w_sum[LGW-1:0]]) begin
        w_found = 1'b1;
        w_pick  = w_sum[LGW-1:0];
      end
    end
  end

  // Select the winning requester's command fields and range-check its address.
  // The check runs on the value being latched so REJECT can follow arbitration directly.
  always_comb begin
    w_sel_addr  = '0;
    w_sel_write = 1'b0;
    w_sel_wdata = '0;
    w_sel_strb  = '0;
    w_sel_prot  = '0;
    for (int unsigned i = 0; i < NREQ; i++) begin
      if (w_pick == LGW'(i)) begin
        w_sel_addr  = req_addr[i*ADDR_WIDTH +: ADDR_WIDTH];
        w_sel_write = req_write[i];
        w_sel_wdata = req_wdata[i*DATA_WIDTH +: DATA_WIDTH];
        w_sel_strb  = req_strb[i*DATA_STRB +: DATA_STRB];
        w_sel_prot  = req_prot[i*3 +: 3];
      end
    end
    w_in_range = (w_sel_addr >= BASE_ADDR) && ({1'b0, w_sel_addr} < LIMIT);
  end

  // One-hot form of the current owner, used for gnt and done.
  always_comb begin
    w_onehot               = '0;
    w_onehot[r_last_grant] = 1'b1;
  end

`ifdef APB_TIMEOUT_EN
  localparam int unsigned TW = $clog2(TIMEOUT_CYCLES + 1);
  logic [TW-1:0] r_tmo_cnt;

  // Wait-state counter: cleared outside ACCESS, counts ACCESS cycles with pready low.
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      r_tmo_cnt <= '0;
    end else if (r_state != S_ACCESS) begin
      r_tmo_cnt <= '0;
    end else if (!pready) begin
      r_tmo_cnt <= r_tmo_cnt + TW'(1);
    end
  end

  assign w_tmo_hit = (r_state == S_ACCESS) && !pready &&
                     (r_tmo_cnt == TW'(TIMEOUT_CYCLES - 1));
`else
  logic w_unused_tmo;
  assign w_unused_tmo = (TIMEOUT_CYCLES != 0);
  assign w_tmo_hit    = 1'b0;
`endif

  // State register.
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_n;
    end
  end

  // Next-state and APB phase/grant decode.
  always_comb begin
    w_state_n = r_state;
    w_psel    = 1'b0;
    w_penable = 1'b0;
    w_gnt     = '0;
    case (r_state)
      S_IDLE: begin
        if (w_found) begin
          w_state_n = w_in_range ? S_SETUP : S_REJECT;
        end
      end
      S_SETUP: begin
        w_psel    = 1'b1;
        w_gnt     = w_onehot;
        w_state_n = S_ACCESS;
      end
      S_ACCESS: begin
        w_psel    = 1'b1;
        w_penable = 1'b1;
        w_gnt     = w_onehot;
        if (pready || w_tmo_hit) begin
          w_state_n = S_IDLE;
        end
      end
      S_REJECT: begin
        w_state_n = S_IDLE;
      end
      default: begin
        w_state_n = S_IDLE;
      end
    endcase
  end

  // Latch the winner's command and update last_grant on every arbitration, rejected or not.
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      r_last_grant <= LGW'(NREQ - 1);
      r_addr       <= '0;
      r_write      <= 1'b0;
      r_wdata      <= '0;
      r_strb       <= '0;
      r_prot       <= '0;
    end else if (r_state == S_IDLE && w_found) begin
      r_last_grant <= w_pick;
      r_addr       <= w_sel_addr;
      r_write      <= w_sel_write;
      r_wdata      <= w_sel_wdata;
      r_strb       <= w_sel_strb;
      r_prot       <= w_sel_prot;
    end
  end

  // Completion: one-cycle done to the owner with response data and error flag.
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      r_done      <= '0;
      r_rsp_rdata <= '0;
      r_rsp_err   <= 1'b0;
    end else begin
      r_done <= '0;
      if (r_state == S_ACCESS && pready) begin
        r_done      <= w_onehot;
        r_rsp_rdata <= r_write ? '0 : prdata;
        r_rsp_err   <= pslverr;
      end else if (r_state == S_REJECT || w_tmo_hit) begin
        r_done      <= w_onehot;
        r_rsp_rdata <= '0;
        r_rsp_err   <= 1'b1;
      end
    end
  end

  assign gnt       = w_gnt;
  assign done      = r_done;
  assign rsp_rdata = r_rsp_rdata;
  assign rsp_err   = r_rsp_err;
  assign psel      = w_psel;
  assign penable   = w_penable;
  assign paddr     = r_addr;
  assign pprot     = r_prot;
  assign pwrite    = r_write;
  assign pwdata    = r_wdata;
  assign pstrb     = r_strb;

endmodule

// File: tb/tb_apb_req_arbiter.sv
// Directed bench for apb_req_arbiter with a 16-word APB slave model.
// Honors APB_TIMEOUT_EN to select the expected ACCESS-timeout behaviour.
`timescale 1ns/1ps
module tb_apb_req_arbiter;
  localparam int unsigned NREQ = 4;

  logic         clk = 1'b0;
  logic         nrst;
  logic [3:0]   req;
  logic [127:0] req_addr;
  logic [3:0]   req_write;
  logic [127:0] req_wdata;
  logic [15:0]  req_strb;
  logic [11:0]  req_prot;
  logic [3:0]   gnt;
  logic [3:0]   done;
  logic [31:0]  rsp_rdata;
  logic         rsp_err;
  logic [31:0]  paddr;
  logic [2:0]   pprot;
  logic         pwrite;
  logic [31:0]  pwdata;
  logic [3:0]   pstrb;
  logic         psel;
  logic         penable;
  logic         pready;
  logic         pslverr;
  logic [31:0]  prdata;
  logic [31:0]  mem [16];

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  apb_req_arbiter #(
    .NREQ(NREQ), .ADDR_WIDTH(32), .DATA_WIDTH(32), .TIMEOUT_CYCLES(16)
  ) dut (
    .clk(clk), .nrst(nrst), .req(req), .req_addr(req_addr), .req_write(req_write),
    .req_wdata(req_wdata), .req_strb(req_strb), .req_prot(req_prot), .gnt(gnt),
    .done(done), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err), .paddr(paddr),
    .pprot(pprot), .pwrite(pwrite), .pwdata(pwdata), .pstrb(pstrb), .psel(psel),
    .penable(penable), .pready(pready), .pslverr(pslverr), .prdata(prdata)
  );

  // Slave register file: word i preloads to C0DE_0000+i, writes land on the completing ACCESS edge.
  always @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      for (int i = 0; i < 16; i++) mem[i] <= 32'hC0DE_0000 + i;
    end else if (psel && penable && pready && pwrite) begin
      mem[paddr[3:0]] <= pwdata;
    end
  end
  assign prdata = mem[paddr[3:0]];

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick;
    @(negedge clk);
  endtask

  task automatic set_req(input int i, input logic [31:0] a, input logic w,
                         input logic [31:0] d, input logic [3:0] s, input logic [2:0] p);
    req_addr[i*32 +: 32] = a;
    req_write[i]         = w;
    req_wdata[i*32 +: 32] = d;
    req_strb[i*4 +: 4]   = s;
    req_prot[i*3 +: 3]   = p;
    req[i]               = 1'b1;
  endtask

  // Zero-wait transfer: SETUP, ACCESS, then done on the third negedge after arbitration.
  task automatic chk_xfer(input string tag, input int i, input logic [31:0] a, input logic w,
                          input logic [31:0] d, input logic [3:0] s, input logic [2:0] p,
                          input logic [31:0] exp_rd, input logic exp_err);
    logic [3:0] oh;
    oh = 4'(1 << i);
    tick;
    chk({tag, ".setup_psel"}, psel, 1);
    chk({tag, ".setup_penable"}, penable, 0);
    chk({tag, ".setup_gnt"}, gnt, oh);
    chk({tag, ".setup_done"}, done, 0);
    chk({tag, ".paddr"}, paddr, a);
    chk({tag, ".pwrite"}, pwrite, w);
    chk({tag, ".pwdata"}, pwdata, d);
    chk({tag, ".pstrb"}, pstrb, s);
    chk({tag, ".pprot"}, pprot, p);
    tick;
    chk({tag, ".access_psel"}, psel, 1);
    chk({tag, ".access_penable"}, penable, 1);
    chk({tag, ".access_gnt"}, gnt, oh);
    chk({tag, ".access_done"}, done, 0);
    tick;
    chk({tag, ".done"}, done, oh);
    chk({tag, ".rdata"}, rsp_rdata, exp_rd);
    chk({tag, ".err"}, rsp_err, exp_err);
    chk({tag, ".idle_psel"}, psel, 0);
    chk({tag, ".idle_gnt"}, gnt, 0);
  endtask

  // Rejected command: no bus activity, done with error two cycles after arbitration.
  task automatic chk_rej(input string tag, input int i);
    logic [3:0] oh;
    oh = 4'(1 << i);
    tick;
    chk({tag, ".rej_psel"}, psel, 0);
    chk({tag, ".rej_penable"}, penable, 0);
    chk({tag, ".rej_gnt"}, gnt, 0);
    chk({tag, ".rej_done0"}, done, 0);
    tick;
    chk({tag, ".rej_done"}, done, oh);
    chk({tag, ".rej_err"}, rsp_err, 1);
    chk({tag, ".rej_rdata"}, rsp_rdata, 0);
    chk({tag, ".rej_psel2"}, psel, 0);
  endtask

  initial begin
    int bad;
    nrst = 1'b0; req = '0; req_addr = '0; req_write = '0; req_wdata = '0;
    req_strb = '0; req_prot = '0; pready = 1'b1; pslverr = 1'b0;
    repeat (2) tick;
    chk("rst.psel", psel, 0);
    chk("rst.penable", penable, 0);
    chk("rst.gnt", gnt, 0);
    chk("rst.done", done, 0);
    chk("rst.rsp_err", rsp_err, 0);
    chk("rst.rsp_rdata", rsp_rdata, 0);
    chk("rst.paddr", paddr, 0);
    chk("rst.pwdata", pwdata, 0);
    chk("rst.pstrb", pstrb, 0);
    chk("rst.pwrite", pwrite, 0);
    nrst = 1'b1;
    tick;

    // All four requesters at once: served 0,1,2,3.
    for (int i = 0; i < 4; i++) set_req(i, 32'hA200_0004 + i, 1'b0, 32'h0, 4'hF, 3'b000);
    for (int k = 0; k < 4; k++) begin
      chk_xfer("cont", k, 32'hA200_0004 + k, 1'b0, 32'h0, 4'hF, 3'b000, 32'hC0DE_0004 + k, 1'b0);
      req[k] = 1'b0;
    end
    tick;

    // req0 and req2 held continuously: alternate 0,2,0,2.
    set_req(0, 32'hA200_0008, 1'b0, 32'h0, 4'hF, 3'b000);
    set_req(2, 32'hA200_0009, 1'b0, 32'h0, 4'hF, 3'b000);
    for (int r = 0; r < 4; r++) begin
      if (r % 2 == 0)
        chk_xfer("alt0", 0, 32'hA200_0008, 1'b0, 32'h0, 4'hF, 3'b000, 32'hC0DE_0008, 1'b0);
      else
        chk_xfer("alt2", 2, 32'hA200_0009, 1'b0, 32'h0, 4'hF, 3'b000, 32'hC0DE_0009, 1'b0);
    end
    req[0] = 1'b0; req[2] = 1'b0;
    tick;

    // Write then read back.
    set_req(0, 32'hA200_0003, 1'b1, 32'hDEAD_BEEF, 4'hF, 3'b010);
    chk_xfer("wr", 0, 32'hA200_0003, 1'b1, 32'hDEAD_BEEF, 4'hF, 3'b010, 32'h0, 1'b0);
    req[0] = 1'b0;
    tick;
    set_req(0, 32'hA200_0003, 1'b0, 32'h0, 4'hF, 3'b000);
    chk_xfer("rd", 0, 32'hA200_0003, 1'b0, 32'h0, 4'hF, 3'b000, 32'hDEAD_BEEF, 1'b0);
    req[0] = 1'b0;
    tick;

    // One past the top of the window: rejected.
    set_req(1, 32'hA200_0010, 1'b0, 32'h0, 4'hF, 3'b000);
    chk_rej("oor_hi", 1);
    req[1] = 1'b0;
    tick;

    // Rejection moved last_grant to 1, so req0 beats req1 next.
    set_req(0, 32'hA200_0001, 1'b0, 32'h0, 4'hF, 3'b000);
    set_req(1, 32'hA200_0002, 1'b0, 32'h0, 4'hF, 3'b000);
    chk_xfer("rr_after_rej0", 0, 32'hA200_0001, 1'b0, 32'h0, 4'hF, 3'b000, 32'hC0DE_0001, 1'b0);
    req[0] = 1'b0;
    chk_xfer("rr_after_rej1", 1, 32'hA200_0002, 1'b0, 32'h0, 4'hF, 3'b000, 32'hC0DE_0002, 1'b0);
    req[1] = 1'b0;
    tick;

    // Last in-window address with slave error.
    pslverr = 1'b1;
    set_req(2, 32'hA200_000F, 1'b0, 32'h0, 4'h3, 3'b101);
    chk_xfer("top_slverr", 2, 32'hA200_000F, 1'b0, 32'h0, 4'h3, 3'b101, 32'hC0DE_000F, 1'b1);
    req[2] = 1'b0; pslverr = 1'b0;
    tick;

    // Just below the window: rejected.
    set_req(3, 32'hA1FF_FFFF, 1'b0, 32'h0, 4'hF, 3'b000);
    chk_rej("oor_lo", 3);
    req[3] = 1'b0;
    tick;

    // Three wait states: done at T+6.
    pready = 1'b0;
    set_req(2, 32'hA200_0008, 1'b0, 32'h0, 4'hF, 3'b001);
    tick;
    chk("ws.setup_gnt", gnt, 4'b0100);
    chk("ws.setup_penable", penable, 0);
    for (int w = 0; w < 3; w++) begin
      tick;
      chk("ws.wait_penable", penable, 1);
      chk("ws.wait_psel", psel, 1);
      chk("ws.wait_paddr", paddr, 32'hA200_0008);
      chk("ws.wait_pprot", pprot, 3'b001);
      chk("ws.wait_done", done, 0);
    end
    tick;
    chk("ws.last_penable", penable, 1);
    chk("ws.last_done", done, 0);
    pready = 1'b1;
    tick;
    chk("ws.done", done, 4'b0100);
    chk("ws.rdata", rsp_rdata, 32'hC0DE_0008);
    chk("ws.err", rsp_err, 0);
    req[2] = 1'b0;
    tick;

    // Slave never ready.
    pready = 1'b0;
    set_req(3, 32'hA200_0009, 1'b0, 32'h0, 4'hF, 3'b000);
    tick;
    chk("tmo.setup_gnt", gnt, 4'b1000);
    bad = 0;
`ifdef APB_TIMEOUT_EN
    for (int c = 0; c < 16; c++) begin
      tick;
      if (!(penable === 1'b1 && done === 4'b0000)) bad++;
    end
    chk("tmo.wait_stable", bad, 0);
    tick;
    chk("tmo.done", done, 4'b1000);
    chk("tmo.err", rsp_err, 1);
    chk("tmo.rdata", rsp_rdata, 0);
    chk("tmo.psel", psel, 0);
    req[3] = 1'b0; pready = 1'b1;
    tick;
`else
    for (int c = 0; c < 40; c++) begin
      tick;
      if (!(penable === 1'b1 && done === 4'b0000)) bad++;
    end
    chk("notmo.wait_forever", bad, 0);
    pready = 1'b1;
    tick;
    chk("notmo.done", done, 4'b1000);
    chk("notmo.rdata", rsp_rdata, 32'hC0DE_0009);
    chk("notmo.err", rsp_err, 0);
    req[3] = 1'b0;
    tick;
`endif

    // Reset in ACCESS: bus drops at once, no done, req0 wins afterwards.
    pready = 1'b0;
    set_req(1, 32'hA200_0004, 1'b0, 32'h0, 4'hF, 3'b000);
    tick;
    chk("mrst.setup_gnt", gnt, 4'b0010);
    tick;
    chk("mrst.access_penable", penable, 1);
    #2 nrst = 1'b0;
    #1;
    chk("mrst.async_psel", psel, 0);
    chk("mrst.async_penable", penable, 0);
    chk("mrst.async_gnt", gnt, 0);
    req[1] = 1'b0;
    tick;
    chk("mrst.no_done0", done, 0);
    tick;
    chk("mrst.no_done1", done, 0);
    nrst = 1'b1; pready = 1'b1;
    set_req(0, 32'hA200_0005, 1'b0, 32'h0, 4'hF, 3'b000);
    set_req(2, 32'hA200_0006, 1'b0, 32'h0, 4'hF, 3'b000);
    chk_xfer("post_rst0", 0, 32'hA200_0005, 1'b0, 32'h0, 4'hF, 3'b000, 32'hC0DE_0005, 1'b0);
    req[0] = 1'b0;
    chk_xfer("post_rst2", 2, 32'hA200_0006, 1'b0, 32'h0, 4'hF, 3'b000, 32'hC0DE_0006, 1'b0);
    req[2] = 1'b0;
    tick;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
